bus_accum_ctrl: RTL and testbench

Parametrised bus interface controller with an integrated accumulator datapath. After a start pulse it clears the accumulator, then accepts data words from an upstream valid/ready bus and adds each one. It stops when the sum reaches a programmable limit or a word-count bound is hit, then holds the result with `done` until the consumer acknowledges. It sits between a streaming producer and a register-level consumer, and generalises the fixed clear/load/add controller with parametrised widths, a word bound, saturation and a proper handshake.

---
 rtl/bus_accum_ctrl.sv | 127 ++++++++++++
 tb/tb_bus_accum_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_accum_ctrl.sv
// bus_accum_ctrl
//   Valid/ready sink with an accumulator. A start pulse (seen in IDLE)
//   clears the accumulator. The block then takes upstream words one at a
//   time and adds each one, saturating at the full-scale value. The run
//   stops when acc >= limit or MAX_WORDS words have been taken. The result
//   then stays on the outputs with done high until ack arrives.
//
// Parameters
//   DATA_W     input word width
//   ACC_W      accumulator width (>= DATA_W)
//   MAX_WORDS  word bound per run (>= 1)
//
// Ports
//   clk, rst_n  clock (rising edge); asynchronous active-low reset
//   start       begin a run (IDLE only)
//   limit       termination threshold, held stable during a run
//   in_valid    upstream word valid
//   in_data     upstream word, zero-extended into the accumulator
//   in_ready    word accepted this cycle (WAIT and not terminated)
//   ack         consumer acknowledge (DONE only)
//   acc         registered accumulator
//   count       words accepted this run
//   overflow    sticky: some add saturated during this run
//   busy        high in WAIT and ADD
//   done        high in DONE
module bus_accum_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 16,
  parameter int MAX_WORDS = 4,
  localparam int CNT_W    = $clog2(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ACC_W-1:0]  limit,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              ack,
  output logic [ACC_W-1:0]  acc,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ADD,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [DATA_W-1:0]  hold;
  logic [ACC_W:0]     sum;
  logic               term;

  // Use only registered values here. That keeps in_ready a Moore output
  // with no combinational path from in_valid.
  assign term = (acc >= limit) || (count == CNT_W'(MAX_WORDS));

  // One extra bit catches the carry out, and that carry is the saturation flag.
  assign sum = {1'b0, acc} + (ACC_W + 1)'(hold);

  // NOTE: sequential state uses non-blocking assignments. All registers
  // then update together at the edge, whatever order the blocks are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // NOTE: state_n gets a default before the case. Every path through the
  // block then assigns it, so no latch is inferred.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (start) state_n = S_WAIT;
      S_WAIT: begin
        // Termination wins over a pending word, so nothing is consumed
        // once the stop condition holds.
        if (term)          state_n = S_DONE;
        else if (in_valid) state_n = S_ADD;
      end
      S_ADD:  state_n = S_WAIT;
      S_DONE: if (ack) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: the holding register is a single word, not a memory. It is reset
  // with the rest of the datapath, so a mid-run reset leaves no stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
      hold     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
          end
        end
        S_WAIT: begin
          if (!term && in_valid) hold <= in_data;
        end
        S_ADD: begin
          acc      <= sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
          overflow <= overflow | sum[ACC_W];
          // ADD is entered only when the word bound was not reached, so
          // this increment cannot exceed MAX_WORDS.
          count    <= count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready = (state == S_WAIT) && !term;
  assign busy     = (state == S_WAIT) || (state == S_ADD);
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_bus_accum_ctrl.sv
// Testbench for bus_accum_ctrl (DATA_W=8, ACC_W=9, MAX_WORDS=4).
// Inputs change and outputs are sampled on the falling edge. A reference
// model computes each run's expected result from the word list and limit.
module tb_bus_accum_ctrl;

  localparam int DATA_W    = 8;
  localparam int ACC_W     = 9;
  localparam int MAX_WORDS = 4;
  localparam int CNT_W     = $clog2(MAX_WORDS + 1);
  localparam int ACC_MAX   = (1 << ACC_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ACC_W-1:0]  limit = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              ack = 1'b0;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc[$];
  int done_cyc;

  bus_accum_ctrl #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .limit(limit),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ack(ack), .acc(acc), .count(count), .overflow(overflow),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Expected outcome of one run. Words are added in order, with
  // saturation, until the sum reaches the limit, the word bound is hit,
  // or the list runs out.
  task automatic model(input int lim, input int words[$],
                       output int m_acc, output int m_cnt, output int m_ovf);
    m_acc = 0; m_cnt = 0; m_ovf = 0;
    while (!(m_acc >= lim || m_cnt == MAX_WORDS) && m_cnt < words.size()) begin
      m_acc += words[m_cnt];
      if (m_acc > ACC_MAX) begin
        m_acc = ACC_MAX;
        m_ovf = 1;
      end
      m_cnt++;
    end
  endtask

  // Runs one transaction and returns at the first falling edge with done
  // high. gaps adds random in_valid bubbles. early_ack raises ack once the
  // model says every word has been accepted.
  task automatic run(input string tag, input int lim, input int words[$],
                     input bit gaps, input bit early_ack, output int exp_acc);
    int m_acc, m_cnt, m_ovf, idx;
    model(lim, words, m_acc, m_cnt, m_ovf);
    exp_acc = m_acc;
    limit = ACC_W'(lim);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_wait_busy"}, busy, 1);
    check({tag, "_wait_acc0"}, acc, 0);
    check({tag, "_wait_cnt0"}, count, 0);
    idx = 0;
    acc_cyc.delete();
    for (int k = 0; k < 200 && !done; k++) begin
      if (idx < words.size() && (!gaps || $urandom_range(1, 0) == 1)) begin
        in_valid = 1'b1;
        in_data  = DATA_W'(words[idx]);
      end else begin
        in_valid = 1'b0;
      end
      if (early_ack && idx == m_cnt) ack = 1'b1;
      if (in_valid && in_ready) begin
        acc_cyc.push_back(cyc);
        idx++;
      end
      step();
    end
    done_cyc = cyc;
    check({tag, "_done"}, done, 1);
    check({tag, "_acc"}, acc, m_acc);
    check({tag, "_count"}, count, m_cnt);
    check({tag, "_ovf"}, overflow, m_ovf);
    check({tag, "_accepted"}, idx, m_cnt);
  endtask

  task automatic ack_idle(input string tag, input int exp_acc);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check({tag, "_ack_done"}, done, 0);
    check({tag, "_ack_busy"}, busy, 0);
    check({tag, "_ack_acc"}, acc, exp_acc);
  endtask

  initial begin
    int ea;
    int w[$];

    // Reset with random inputs applied.
    start    = 1'($urandom);
    ack      = 1'($urandom);
    in_valid = 1'($urandom);
    in_data  = DATA_W'($urandom);
    limit    = ACC_W'($urandom);
    #3;
    check("rst_acc", acc, 0);
    check("rst_cnt", count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    step(); step();
    start = 0; ack = 0; in_valid = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
    end

    // Count bound. The fifth word stays offered and must never be taken.
    w = '{10, 20, 30, 40, 50};
    run("bound", 511, w, 0, 0, ea);
    check("bound_acc100", acc, 100);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("bound_alt_cycle", acc_cyc[i] - acc_cyc[i-1], 2);
    check("bound_done_lat", done_cyc - acc_cyc[acc_cyc.size()-1], 3);
    for (int i = 0; i < 3; i++) begin
      check("bound_no5th", in_ready, 0);
      step();
    end
    check("bound_cnt_hold", count, 4);
    in_valid = 1'b0;
    ack_idle("bound", 100);

    // Limit stop. The third word stays valid but is not consumed.
    w = '{30, 30, 30};
    run("limit", 50, w, 0, 0, ea);
    check("limit_acc60", acc, 60);
    check("limit_valid_held", in_valid, 1);
    check("limit_ready", in_ready, 0);
    in_valid = 1'b0;
    ack_idle("limit", 60);

    // Saturation.
    w = '{255, 255, 255};
    run("sat", 511, w, 0, 0, ea);
    check("sat_acc", acc, 511);
    check("sat_ovf1", overflow, 1);
    in_valid = 1'b0;
    ack_idle("sat", 511);

    // Zero limit, with ack pulsed in WAIT and start pulsed in DONE.
    limit = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("zero_wait_busy", busy, 1);
    check("zero_wait_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 8'd77;
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("zero_done", done, 1);
    check("zero_cnt", count, 0);
    step();
    check("zero_ack_ignored", done, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("zero_start_ignored", done, 1);
    check("zero_busy", busy, 0);
    check("zero_acc", acc, 0);
    check("zero_cnt2", count, 0);
    in_valid = 1'b0;
    ack_idle("zero", 0);

    // Mid-run reset, asserted between clock edges.
    limit = 9'd511;
    start = 1'b1;
    step();
    start = 1'b0;
    w = '{10, 20};
    begin
      int idx = 0;
      for (int k = 0; k < 50 && acc != 30; k++) begin
        in_valid = (idx < 2);
        in_data  = (idx < 2) ? DATA_W'(w[idx]) : '0;
        if (in_valid && in_ready) idx++;
        step();
      end
    end
    in_valid = 1'b0;
    check("mid_acc30", acc, 30);
    check("mid_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_acc", acc, 0);
    check("mid_rst_cnt", count, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ready", in_ready, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    w = '{5, 6, 7, 8};
    run("after_rst", 511, w, 0, 0, ea);
    check("after_rst_acc", acc, 26);
    in_valid = 1'b0;
    ack_idle("after_rst", 26);

    // Random runs: random limits and words, valid bubbles, sometimes early ack.
    for (int r = 0; r < 25; r++) begin
      int lim;
      bit eack;
      w.delete();
      for (int i = 0; i < MAX_WORDS; i++) w.push_back(int'($urandom_range(255, 0)));
      lim  = (r % 3 == 0) ? int'($urandom_range(ACC_MAX, 0)) : int'($urandom_range(400, 0));
      eack = 1'($urandom);
      run("rand", lim, w, 1, eack, ea);
      in_valid = 1'b0;
      ack_idle("rand", ea);
      repeat ($urandom_range(3, 0)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
